// File: rtl/fir_pkg.sv
// Shared constants, sample type and constant helpers for the FIR output path.
package fir_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FILTER_SIZE = 172;
    localparam int unsigned WARMUP_DEF  = FILTER_SIZE + 1;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Ceiling log2 for elaboration-time sizing (log2(1) = 0).
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_decim_out_buffer_if.sv
// Valid/ready output stream carrying decimated samples to the next stage.
interface fir_decim_out_buffer_if #(
    parameter int unsigned DATA_W = fir_pkg::DATA_W
) ();

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty derive from a level counter, pointers wrap naturally.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned PTR_W = log2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              wr_ok;

    assign full   = (level == LVL_W'(FIFO_DEPTH));
    assign empty  = (level == '0);
    assign pop_ok = pop && !empty && !flush;
    assign wr_ok  = push && (!full || pop_ok) && !flush;
    assign rdata  = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset needed since reads of empty slots are masked.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_decim_out_buffer.sv
// FIR output buffer: drops warm-up samples, decimates by DECIM, queues results
// on a valid/ready stream. Define AVERAGE_DECIM_EN to push the floored mean of
// each DECIM-sample block instead of the phase-0 sample.
module fir_decim_out_buffer
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W     = fir_pkg::DATA_W,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WARMUP     = fir_pkg::WARMUP_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [DATA_W-1:0]             fir_in,
    input  logic                          flush,
    fir_decim_out_buffer_if.master        m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned PH_W = log2(DECIM);
    localparam int unsigned WU_W = log2(WARMUP + 1);

    logic [WU_W-1:0]   warm_cnt;
    logic              warm_done;
    logic              sample_en;
    logic [PH_W-1:0]   phase;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign warm_done = (warm_cnt == WU_W'(WARMUP));
    assign sample_en = en && warm_done;
    assign pop       = m.m_valid && m.m_ready;
    assign m.m_valid = !fifo_empty;

    // Warm-up counter saturates at WARMUP; only reset restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_cnt <= '0;
        end else if (en && !warm_done) begin
            warm_cnt <= warm_cnt + WU_W'(1);
        end
    end

    // Decimation phase advances on every post-warm-up sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (flush) begin
            phase <= '0;
        end else if (sample_en) begin
            phase <= phase + PH_W'(1);
        end
    end

`ifdef AVERAGE_DECIM_EN
    localparam int unsigned ACC_W = DATA_W + PH_W;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] fin_ext;

    assign fin_ext = ACC_W'($signed(fir_in));

    // Block sum restarts with the phase-0 sample.
    always_comb begin
        acc_next = fin_ext;
        if (phase != '0) begin
            acc_next = acc + fin_ext;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (flush) begin
            acc <= '0;
        end else if (sample_en) begin
            acc <= acc_next;
        end
    end

    // Push the floored block mean at the last phase.
    always_comb begin
        push      = 1'b0;
        push_data = DATA_W'(acc_next >>> PH_W);
        if (sample_en && phase == PH_W'(DECIM - 1)) begin
            push = 1'b1;
        end
    end
`else
    // Keep the phase-0 sample, drop the rest.
    always_comb begin
        push      = 1'b0;
        push_data = fir_in;
        if (sample_en && phase == '0) begin
            push = 1'b1;
        end
    end
`endif

    // Sticky drop flag: push into a full FIFO that is not draining this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (m.m_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// Randomized + directed bench for fir_decim_out_buffer against a queue model.
module tb_fir_decim_out_buffer;

    localparam int unsigned DATA_W     = 16;
    localparam int          DECIM      = 4;
    localparam int          FIFO_DEPTH = 8;
    localparam int          WARMUP     = 173;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic              flush = 1'b0;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] fir_in = '0;
    logic [3:0]        fifo_level;
    logic              overflow;

    fir_decim_out_buffer_if #(.DATA_W(DATA_W)) bus ();
    assign bus.m_ready = m_ready;

    always #5 clk = ~clk;

    fir_decim_out_buffer #(
        .DATA_W     (DATA_W),
        .DECIM      (DECIM),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WARMUP     (WARMUP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fir_in     (fir_in),
        .flush      (flush),
        .m          (bus.master),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    int  vectors = 0;
    int  errors  = 0;
    bit  check_en = 1'b0;

    // Behavioural model: kept-sample queue, sample index within block, sticky drop.
    longint q[$];
    int     wcnt;
    int     kph;
    bit     ovf;
    longint acc;
    bit     m_pop;
    bit     m_push;
    longint m_val;
    longint sv;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            wcnt = 0;
            kph  = 0;
            ovf  = 1'b0;
            acc  = 0;
        end else begin
            sv = longint'($signed(fir_in));
            if (flush) begin
                q.delete();
                kph = 0;
                ovf = 1'b0;
                acc = 0;
            end else begin
                m_pop  = (q.size() > 0) && m_ready;
                m_push = 1'b0;
                m_val  = 0;
                if (en && wcnt == WARMUP) begin
`ifdef AVERAGE_DECIM_EN
                    acc    = (kph == 0) ? sv : acc + sv;
                    m_push = (kph == DECIM - 1);
                    m_val  = (acc >= 0) ? acc / DECIM : -((-acc + DECIM - 1) / DECIM);
`else
                    m_push = (kph == 0);
                    m_val  = sv;
`endif
                    kph = (kph + 1) % DECIM;
                end
                if (m_pop) void'(q.pop_front());
                if (m_push) begin
                    if (q.size() < FIFO_DEPTH) q.push_back(m_val);
                    else ovf = 1'b1;
                end
            end
            if (en && wcnt < WARMUP) wcnt++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en && reset) begin
            chk("m_valid", longint'(bus.m_valid), longint'(q.size() > 0));
            chk("m_data", longint'($signed(bus.m_data)), (q.size() > 0) ? q[0] : 0);
            chk("fifo_level", longint'(fifo_level), longint'(q.size()));
            chk("overflow", longint'(overflow), longint'(ovf));
        end
    end

    task automatic cyc(input bit e, input logic [DATA_W-1:0] d, input bit r, input bit f);
        en      = e;
        fir_in  = d;
        m_ready = r;
        flush   = f;
        @(negedge clk);
    endtask

    longint got[$];

    initial begin
        #1;
        chk("rst_valid", longint'(bus.m_valid), 0);
        chk("rst_data", longint'(bus.m_data), 0);
        chk("rst_level", longint'(fifo_level), 0);
        chk("rst_overflow", longint'(overflow), 0);
        @(negedge clk);
        reset    = 1'b1;
        check_en = 1'b1;

        // Warm-up samples are all discarded.
        repeat (WARMUP) cyc(1'b1, 16'h7FFF, 1'b1, 1'b0);
        chk("warmup_level", longint'(fifo_level), 0);
        chk("warmup_valid", longint'(bus.m_valid), 0);

        // Ramp with free-flowing sink.
        got.delete();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, DATA_W'(1000 + i), 1'b1, 1'b0);
            if (bus.m_valid) got.push_back(longint'($signed(bus.m_data)));
        end
`ifndef AVERAGE_DECIM_EN
        chk("ramp_count", longint'(got.size()), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) chk("ramp_data", got[j], 1000 + 4 * j);
`endif
        cyc(1'b0, '0, 1'b1, 1'b1);

        // Stalled sink: fill, then overflow on the ninth push.
        for (int i = 0; i < 33; i++) begin
            cyc(1'b1, DATA_W'(1000 + i), 1'b0, 1'b0);
`ifndef AVERAGE_DECIM_EN
            if (i == 28) begin
                chk("fill_level28", longint'(fifo_level), 8);
                chk("fill_ovf28", longint'(overflow), 0);
            end
`endif
        end
`ifndef AVERAGE_DECIM_EN
        chk("ovf_set", longint'(overflow), 1);
        chk("ovf_level", longint'(fifo_level), 8);
`endif
        got.delete();
        repeat (8) begin
            got.push_back(longint'($signed(bus.m_data)));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
`ifndef AVERAGE_DECIM_EN
        chk("drain_first", got[0], 1000);
        chk("drain_last", got[7], 1028);
        chk("drain_level", longint'(fifo_level), 0);
        chk("drain_ovf_sticky", longint'(overflow), 1);
`endif
        cyc(1'b0, '0, 1'b1, 1'b1);

        // Full FIFO with push and pop on the same edge.
        for (int i = 0; i < 32; i++) cyc(1'b1, DATA_W'(1000 + i), 1'b0, 1'b0);
        cyc(1'b1, DATA_W'(1032), 1'b1, 1'b0);
`ifndef AVERAGE_DECIM_EN
        chk("pp_level", longint'(fifo_level), 8);
        chk("pp_ovf", longint'(overflow), 0);
`endif
        got.delete();
        repeat (8) begin
            got.push_back(longint'($signed(bus.m_data)));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
`ifndef AVERAGE_DECIM_EN
        chk("pp_head", got[0], 1004);
        chk("pp_tail", got[7], 1032);
`endif
        cyc(1'b0, '0, 1'b1, 1'b1);

        // Asynchronous reset mid-stream, then a full new warm-up.
        for (int i = 0; i < 33; i++) cyc(1'b1, DATA_W'(1000 + i), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
`ifndef AVERAGE_DECIM_EN
        chk("pre_rst_level", longint'(fifo_level), 5);
        chk("pre_rst_ovf", longint'(overflow), 1);
`endif
        #2 reset = 1'b0;
        #1;
        chk("async_valid", longint'(bus.m_valid), 0);
        chk("async_data", longint'(bus.m_data), 0);
        chk("async_level", longint'(fifo_level), 0);
        chk("async_ovf", longint'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < WARMUP; i++) cyc(1'b1, DATA_W'(2000 + i), 1'b1, 1'b0);
        chk("rewarm_level", longint'(fifo_level), 0);
        cyc(1'b1, DATA_W'(3000), 1'b0, 1'b0);
`ifndef AVERAGE_DECIM_EN
        chk("rewarm_push_level", longint'(fifo_level), 1);
        chk("rewarm_push_data", longint'($signed(bus.m_data)), 3000);
`endif

`ifdef AVERAGE_DECIM_EN
        // Block averages with floor rounding.
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, -16'sd4, 1'b0, 1'b0);
        cyc(1'b1, -16'sd3, 1'b0, 1'b0);
        cyc(1'b1, -16'sd2, 1'b0, 1'b0);
        chk("avg_nopush", longint'(fifo_level), 0);
        cyc(1'b1, -16'sd1, 1'b0, 1'b0);
        chk("avg_neg_level", longint'(fifo_level), 1);
        chk("avg_neg_data", longint'($signed(bus.m_data)), -3);
        for (int i = 4; i < 8; i++) cyc(1'b1, DATA_W'(i), 1'b0, 1'b0);
        chk("avg_pos_level", longint'(fifo_level), 2);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("avg_pos_data", longint'($signed(bus.m_data)), 5);
`endif

        // Randomized traffic: congested phase, then mostly draining.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7,
                DATA_W'($urandom),
                (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 99) == 0);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fir_decim_out_buffer.md
Name: fir_decim_out_buffer

Overview:
- Downstream consumer of the symmetric broadcast FIR output (`data_out`, 16-bit, one new sample per `en` cycle).
- Discards FIR warm-up samples, then decimates by DECIM.
- Buffers the decimated samples in a small synchronous FIFO and presents them on a valid/ready stream to the next stage (DAC/serializer/host capture).
- Reports occupancy and a sticky overflow flag.

Parameters:
- DATA_W, 16, sample width; matches FIR output.
- DECIM, 4, decimation factor; power of two, ≥2.
- FIFO_DEPTH, 8, buffer entries; power of two, ≥2.
- WARMUP, 173, number of `en` samples discarded after reset (FILTER_SIZE+1).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- en  in  1  sample strobe, same net that enables the FIR.
- fir_in  in  DATA_W  signed sample from FIR `data_out`.
- flush  in  1  synchronous clear of FIFO, phase and overflow.
- m_data  out  DATA_W  head-of-FIFO sample; forced 0 when m_valid=0.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  downstream accepts m_data this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
- overflow  out  1  sticky; set when a decimated sample is dropped.

Behaviour:
- Reset (reset=0, async): warm-up count=0, phase=0, pointers=0, level=0, overflow=0, m_valid=0, m_data=0.
- Warm-up: each edge with en=1 increments the warm-up counter until it equals WARMUP (saturates there). Samples captured while count<WARMUP are discarded.
- Decimation: after warm-up, phase counts 0..DECIM-1 on each en=1 edge and wraps to 0. Push occurs on an en=1 edge with phase==0. The first post-warm-up sample is kept.
- en=0: nothing advances; FIFO pop still permitted.
- Pop: on an edge with m_valid & m_ready; rd_ptr advances.
- Latency: a sample pushed at edge N appears on m_data with m_valid=1 after edge N (next cycle), if the FIFO was empty.
- Level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full (level==FIFO_DEPTH) with push and no pop: sample dropped, pointers unchanged, overflow←1.
- Full with simultaneous push and pop: both succeed, level stays FIFO_DEPTH, no overflow.
- Empty with push and m_ready=1: no pop that cycle (m_valid was 0); level becomes 1.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty come from the level counter.
- flush=1: pointers, level, phase and overflow → 0. Warm-up count is unchanged. Flush overrides push/pop on the same edge.
- Reset mid-operation: all state cleared asynchronously; the warm-up restarts on release. Reset release is synchronous to clk upstream.
- overflow clears only on reset or flush.

Optional Feature:
- Macro: AVERAGE_DECIM_EN.
- Defined: a signed accumulator of width DATA_W+log2(DECIM) sums the DECIM samples of phases 0..DECIM-1.
  - At phase DECIM-1 the pushed value is sum >>> log2(DECIM) (arithmetic shift, floor, truncate to DATA_W).
  - The accumulator reloads with the phase-0 sample; it clears on flush and reset.
  - The first push occurs DECIM−1 samples after warm-up.
- Undefined: plain sample-and-drop at phase 0. No accumulator is synthesized.

Decomposition:
- Package fir_pkg holds:
  - DATA_W constant.
  - FILTER_SIZE constant.
  - typedef sample_t (signed [DATA_W-1:0]).
  - Log2 constant function.
  - Default WARMUP derived as FILTER_SIZE+1.
- Sub-module sync_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/level/full/empty) holds the storage. Warm-up, phase, optional averaging and overflow logic stay in the top.

Test Plan:
- Reset, then 173 en pulses with fir_in=0x7FFF → no push, fifo_level=0, m_valid=0 throughout.
- After warm-up, en every cycle, fir_in ramp 1000,1001,…, m_ready=1 → m_data sequence 1000,1004,1008,1012, each m_valid for one cycle, level ≤1.
- m_ready=0, ramp from 1000 post-warm-up for 33 samples → level reaches 8 at sample 28. The push at sample 32 is dropped and overflow=1. Then m_ready=1: first pop yields 1000 and the last yields 1028.
- FIFO full, m_ready=1 on the same edge as a phase-0 push → level stays 8, overflow stays 0, tail entry equals the pushed value.
- reset=0 pulled mid-stream (level=5, overflow=1) → outputs 0 immediately without a clock. After release, 173 further samples are discarded before the next push.
- AVERAGE_DECIM_EN: post-warm-up inputs −4,−3,−2,−1 → single push of −3. Inputs 4,5,6,7 → push of 5.
